// File: rtl/ex_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul_unit
// Purpose  : Iterative MUL / MLA unit for the EX stage. Retires RADIX_BITS
//            multiplier bits per cycle with a shift-and-add datapath, stalls
//            the front end through `freeze` while busy, and presents the
//            result to EX/MEM as a one-cycle pulse.
// Optional : MUL_EARLY_TERM_EN - when defined, RUN ends as soon as the
//            remaining multiplier bits are all zero (minimum one RUN cycle).
// Ports    : clk, rst (async, active-high), flush (sync kill)
//            start/accumulate_in/s_in/dest_in/val_rm_in/val_rs_in/val_rn_in/
//            status_in  - decoded instruction from the ID/EX register
//            freeze               - combinational stall request
//            result_valid/wb_en_out/s_out - completion pulse and qualifiers
//            result/dest_out/status_out   - held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module ex_mul_unit #(
  parameter int DATA_W     = 32,
  parameter int DEST_W     = 4,
  parameter int RADIX_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              accumulate_in,
  input  logic              s_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [DATA_W-1:0] val_rs_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [3:0]        status_in,
  output logic              freeze,
  output logic              result_valid,
  output logic              wb_en_out,
  output logic              s_out,
  output logic [DATA_W-1:0] result,
  output logic [DEST_W-1:0] dest_out,
  output logic [3:0]        status_out
);

  localparam int C_STEPS = DATA_W / RADIX_BITS;
  localparam int C_CNT_W = $clog2(C_STEPS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_STEP = C_CNT_W'(C_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mr_q, mr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                s_q, s_d;
  logic [1:0]          cv_q, cv_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                s_out_q, s_out_d;
  logic [DEST_W-1:0]   dest_out_q, dest_out_d;
  logic [3:0]          status_out_q, status_out_d;

  logic [DATA_W-1:0]   digit;
  logic [DATA_W-1:0]   step_acc;
  logic [DATA_W-1:0]   mr_shift;
  logic                last_step;
  logic                unused_status;

  // N and Z are recomputed from the product; only C and V pass through.
  assign unused_status = ^status_in[3:2];

  // Low radix digit of the multiplier, widened so the partial product is a
  // full-width (and therefore naturally truncated) multiply.
  assign digit    = {{(DATA_W-RADIX_BITS){1'b0}}, mr_q[RADIX_BITS-1:0]};
  assign step_acc = acc_q + mcand_q * digit;
  assign mr_shift = mr_q >> RADIX_BITS;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt_q == C_LAST_STEP) || (mr_shift == '0);
`else
  assign last_step = (cnt_q == C_LAST_STEP);
`endif

  always_comb begin
    state_d        = state_q;
    mcand_d        = mcand_q;
    mr_d           = mr_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    dest_d         = dest_q;
    s_d            = s_q;
    cv_d           = cv_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    s_out_d        = 1'b0;
    dest_out_d     = dest_out_q;
    status_out_d   = status_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = val_rm_in;
          mr_d    = val_rs_in;
          acc_d   = accumulate_in ? val_rn_in : '0;
          cnt_d   = '0;
          dest_d  = dest_in;
          s_d     = s_in;
          cv_d    = status_in[1:0];
        end
      end
      ST_RUN: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << RADIX_BITS;
        mr_d    = mr_shift;
        cnt_d   = cnt_q + C_CNT_W'(1);
        if (last_step) begin
          // Output registers load on the RUN->DONE edge so the pulse and
          // its payload are visible together during DONE.
          state_d        = ST_DONE;
          result_d       = step_acc;
          result_valid_d = 1'b1;
          s_out_d        = s_q;
          dest_out_d     = dest_q;
          status_out_d   = {step_acc[DATA_W-1], (step_acc == '0), cv_q};
        end
      end
      ST_DONE: begin
        // start still shows the instruction being released; ignore it.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything: drop the operation and leave the held
    // outputs untouched.
    if (flush) begin
      state_d        = ST_IDLE;
      result_d       = result_q;
      result_valid_d = 1'b0;
      s_out_d        = 1'b0;
      dest_out_d     = dest_out_q;
      status_out_d   = status_out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mcand_q        <= '0;
      mr_q           <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      dest_q         <= '0;
      s_q            <= 1'b0;
      cv_q           <= 2'b00;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      s_out_q        <= 1'b0;
      dest_out_q     <= '0;
      status_out_q   <= 4'b0000;
    end else begin
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      mr_q           <= mr_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      dest_q         <= dest_d;
      s_q            <= s_d;
      cv_q           <= cv_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      s_out_q        <= s_out_d;
      dest_out_q     <= dest_out_d;
      status_out_q   <= status_out_d;
    end
  end

  assign freeze       = ((state_q == ST_IDLE) && start && !flush) || (state_q == ST_RUN);
  assign result_valid = result_valid_q;
  assign wb_en_out    = result_valid_q;
  assign s_out        = s_out_q;
  assign result       = result_q;
  assign dest_out     = dest_out_q;
  assign status_out   = status_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mul_unit
// Purpose  : Self-checking bench for ex_mul_unit. Expected products, flags
//            and latencies come from plain arithmetic on the operands.
//            Honors MUL_EARLY_TERM_EN for the expected RUN length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mul_unit;

  localparam int DATA_W     = 32;
  localparam int DEST_W     = 4;
  localparam int RADIX_BITS = 1;
  localparam int N_STEPS    = DATA_W / RADIX_BITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              start = 1'b0;
  logic              accumulate_in = 1'b0;
  logic              s_in = 1'b0;
  logic [DEST_W-1:0] dest_in = '0;
  logic [DATA_W-1:0] val_rm_in = '0;
  logic [DATA_W-1:0] val_rs_in = '0;
  logic [DATA_W-1:0] val_rn_in = '0;
  logic [3:0]        status_in = '0;
  logic              freeze;
  logic              result_valid;
  logic              wb_en_out;
  logic              s_out;
  logic [DATA_W-1:0] result;
  logic [DEST_W-1:0] dest_out;
  logic [3:0]        status_out;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] last_result = '0;

  ex_mul_unit #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .RADIX_BITS(RADIX_BITS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start),
    .accumulate_in(accumulate_in), .s_in(s_in), .dest_in(dest_in),
    .val_rm_in(val_rm_in), .val_rs_in(val_rs_in), .val_rn_in(val_rn_in),
    .status_in(status_in), .freeze(freeze), .result_valid(result_valid),
    .wb_en_out(wb_en_out), .s_out(s_out), .result(result),
    .dest_out(dest_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  // Number of RUN cycles the unit should spend on multiplier rs.
  function automatic int run_len(input logic [DATA_W-1:0] rs);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < DATA_W; i++) if (rs[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + RADIX_BITS) / RADIX_BITS;
`else
    return N_STEPS;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction starting in the current cycle (cycle 0), follows
  // it to DONE, then advances one more cycle. start stays high on return so
  // the caller may immediately issue a back-to-back instruction.
  task automatic run_op(input logic [DATA_W-1:0] rm, input logic [DATA_W-1:0] rs,
                        input logic [DATA_W-1:0] rn, input logic acc, input logic s,
                        input logic [DEST_W-1:0] dest, input logic [3:0] st,
                        input string name);
    logic [DATA_W-1:0] exp_res;
    logic [3:0]        exp_st;
    int                exp_lat;
    int                cyc;
    bit                frz_ok;
    exp_res = rm * rs + (acc ? rn : '0);
    exp_st  = {exp_res[DATA_W-1], exp_res == 0, st[1:0]};
    exp_lat = run_len(rs);
    val_rm_in = rm; val_rs_in = rs; val_rn_in = rn; accumulate_in = acc;
    s_in = s; dest_in = dest; status_in = st; flush = 1'b0; start = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b1) begin failures++; $display("FAIL %s freeze_c0 got=%b exp=1", name, freeze); end
    cyc = 0; frz_ok = 1'b1;
    while (result_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
      if (result_valid !== 1'b1 && freeze !== 1'b1) frz_ok = 1'b0;
    end
    checks++;
    if (!frz_ok) begin failures++; $display("FAIL %s freeze_run dropped before DONE", name); end
    checks++;
    if (cyc != exp_lat + 1) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, exp_lat + 1); end
    checks++;
    if (result !== exp_res) begin failures++; $display("FAIL %s result got=%h exp=%h", name, result, exp_res); end
    checks++;
    if (dest_out !== dest || wb_en_out !== 1'b1 || s_out !== s) begin
      failures++;
      $display("FAIL %s done_ctl got dest=%h wb=%b s=%b exp dest=%h wb=1 s=%b", name, dest_out, wb_en_out, s_out, dest, s);
    end
    checks++;
    if (freeze !== 1'b0) begin failures++; $display("FAIL %s freeze_done got=%b exp=0", name, freeze); end
    if (s) begin
      checks++;
      if (status_out !== exp_st) begin failures++; $display("FAIL %s status got=%b exp=%b", name, status_out, exp_st); end
    end
    last_result = exp_res;
    step();
    checks++;
    if (result_valid !== 1'b0 || wb_en_out !== 1'b0 || s_out !== 1'b0 || result !== exp_res) begin
      failures++;
      $display("FAIL %s after_done got v=%b wb=%b s=%b res=%h exp v=0 wb=0 s=0 res=%h",
               name, result_valid, wb_en_out, s_out, result, exp_res);
    end
  endtask

  task automatic go_idle();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    step(); step();
    checks++;
    if (freeze !== 0 || result_valid !== 0 || wb_en_out !== 0 || s_out !== 0 ||
        result !== '0 || dest_out !== '0 || status_out !== 4'b0) begin
      failures++;
      $display("FAIL reset_state got frz=%b v=%b wb=%b s=%b res=%h dest=%h st=%b exp all 0",
               freeze, result_valid, wb_en_out, s_out, result, dest_out, status_out);
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'd5, 4'b0011, "mul_7x6");
    go_idle();
    run_op(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 4'd3, 4'b0000, "mla_wrap_n");
    go_idle();
    run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd7, 4'b0110, "trunc_z");
    go_idle();
    run_op(32'd123, 32'd0, 32'd77, 1'b1, 1'b1, 4'd1, 4'b0001, "mla_rs0");
    go_idle();
    run_op(32'd9, 32'd3, 32'd0, 1'b0, 1'b0, 4'd2, 4'b0000, "mul_rs3");
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [DATA_W-1:0] rs;
      rs = $urandom >> $urandom_range(0, 31);
      run_op($urandom, rs, $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
             4'($urandom), "random");
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_op(32'd11, 32'd13, 32'd0, 1'b0, 1'b1, 4'd4, 4'b0010, "b2b_first");
    run_op(32'd100, 32'hFF, 32'd5, 1'b1, 1'b1, 4'd8, 4'b0001, "b2b_second");
    go_idle();
  endtask

  task automatic test_flush();
    bit seen;
    // Flush in IDLE overrides start.
    start = 1'b1; flush = 1'b1; val_rs_in = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (freeze !== 1'b0) begin failures++; $display("FAIL flush_idle freeze got=%b exp=0", freeze); end
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (freeze !== 1'b0) begin failures++; $display("FAIL flush_idle next freeze got=%b exp=0", freeze); end
    step();
    // Flush in cycle 10 of a full-length operation.
    val_rm_in = 32'h1234_5678; val_rs_in = 32'hFFFF_FFFF; accumulate_in = 1'b0;
    s_in = 1'b1; dest_in = 4'd6; start = 1'b1;
    for (int c = 0; c < 10; c++) step();
    flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (freeze !== 1'b0 || result_valid !== 1'b0 || result !== last_result) begin
      failures++;
      $display("FAIL flush_run got frz=%b v=%b res=%h exp frz=0 v=0 res=%h", freeze, result_valid, result, last_result);
    end
    seen = 1'b0;
    for (int c = 0; c < N_STEPS + 4; c++) begin
      step();
      if (result_valid !== 1'b0 || freeze !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL flush_quiet activity after flush got=1 exp=0"); end
  endtask

  task automatic test_async_reset();
    run_op(32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 4'd9, 4'b0011, "pre_reset");
    go_idle();
    val_rm_in = 32'hDEAD_BEEF; val_rs_in = 32'hFFFF_FFFF; s_in = 1'b1; dest_in = 4'd12;
    start = 1'b1;
    for (int c = 0; c < 15; c++) step();
    start = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (freeze !== 0 || result_valid !== 0 || wb_en_out !== 0 || s_out !== 0 ||
        result !== '0 || dest_out !== '0 || status_out !== 4'b0) begin
      failures++;
      $display("FAIL async_reset got frz=%b v=%b wb=%b s=%b res=%h dest=%h st=%b exp all 0",
               freeze, result_valid, wb_en_out, s_out, result, dest_out, status_out);
    end
    #2 rst = 1'b0;
    step();
    run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 4'd2, 4'b0000, "post_reset_3x3");
    go_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative multiply / multiply-accumulate unit for the EX stage, consuming the decoded operands and control bits from the ID/EX pipeline register. It implements ARM MUL (Rd = Rm*Rs) and MLA (Rd = Rm*Rs + Rn) over several cycles. While busy it raises `freeze` back to the IF/ID stages and the ID/EX register so the issuing instruction is held. On completion it presents the result, destination, write-back enable and flags to the EX/MEM register for one cycle.

## Interface
- `DATA_W`, 32: operand/result width.
- `DEST_W`, 4: destination register index width.
- `RADIX_BITS`, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4, and the value must divide `DATA_W`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of the in-flight operation (branch taken).
- `start`  in  1  the ID/EX register holds a MUL/MLA instruction.
- `accumulate_in`  in  1  1 = MLA, 0 = MUL.
- `s_in`  in  1  update flags.
- `dest_in`  in  DEST_W  destination register.
- `val_rm_in`  in  DATA_W  multiplicand.
- `val_rs_in`  in  DATA_W  multiplier.
- `val_rn_in`  in  DATA_W  accumulator addend.
- `status_in`  in  4  current NZCV flags ({N,Z,C,V}, bit 3 = N).
- `freeze`  out  1  stall request to the upstream stages and the ID/EX register.
- `result_valid`  out  1  one-cycle completion pulse.
- `wb_en_out`  out  1  equals `result_valid`.
- `s_out`  out  1  latched `s_in`, qualified by `result_valid`.
- `result`  out  DATA_W  product.
- `dest_out`  out  DEST_W  latched destination.
- `status_out`  out  4  new flags.

## Operation
- **States**
  - IDLE: `start`=1 and `flush`=0 → latch operands, `dest_in`, `s_in`, `status_in[1:0]`, clear the step counter, set acc = `accumulate_in` ? `val_rn_in` : 0, go to RUN.
  - RUN: each cycle:
    - acc += mcand * mr[RADIX_BITS-1:0], truncated to DATA_W;
    - mcand <<= RADIX_BITS;
    - mr >>= RADIX_BITS;
    - counter++.
    - After DATA_W/RADIX_BITS steps, go to DONE.
  - DONE:
    - registered `result` = acc;
    - `result_valid`=1;
    - next state is IDLE.
    - `start` is ignored in DONE, because it still reflects the same instruction being released.
- **Freeze**
  - `freeze` = (IDLE & `start` & !`flush`) | RUN. It is combinational.
  - It is low in DONE, so on the DONE edge the pipeline advances and the ID/EX register loads the next instruction.
- **Arithmetic**
  - Products and sums are modulo 2^DATA_W, keeping the low word only.
  - The signed and unsigned low words are identical, so no sign handling is needed.
- **Flags**
  - `status_out` = {result[DATA_W-1], result==0, latched C, latched V}.
  - `status_out` is meaningful only when `s_out`=1.
- **Output holding**
  - `result`, `dest_out` and `status_out` hold their values until the next DONE.
  - `wb_en_out` and `s_out` are 0 outside DONE.
- **Flush**
  - In any state, `flush` forces IDLE on the next edge.
  - There is no `result_valid`, and `freeze` is 0 in the following cycle.
  - `flush` overrides `start` in the same cycle.
- **Reset mid-operation**
  - Returns to IDLE immediately.
  - All registered outputs go to 0.
  - `freeze` = 0 unless `start` is asserted in IDLE.

## Timing
- Reset values: `freeze` 0 (with `start`=0), `result_valid` 0, `wb_en_out` 0, `s_out` 0, `result` 0, `dest_out` 0, `status_out` 0.
- Let N = DATA_W/RADIX_BITS. Cycle numbering:
  - `start` is seen in cycle 0;
  - RUN occupies cycles 1..N;
  - DONE / `result_valid` is in cycle N+1.
  - `freeze` is high in cycles 0..N, i.e. N+1 cycles.
- Default parameters (N=32): `result_valid` in cycle 33.
- Back-to-back MUL: the second `start` is first evaluated in the cycle after DONE.

## Configuration
- **`MUL_EARLY_TERM_EN`**
  - Defined: RUN also exits to DONE when the post-shift multiplier is 0.
    - RUN length = max(1, ceil((msb_index(Rs)+1)/RADIX_BITS)).
    - Rs=0 gives 1 RUN cycle.
    - `freeze` tracks the shortened RUN.
  - Undefined: fixed latency of N RUN cycles.

## Test plan
- **Fixed-latency MUL**
  - Stimulus: macro undefined, MUL Rm=7, Rs=6, `dest_in`=5, `s_in`=1, `status_in`=4'b0011.
  - Response: `freeze` high for cycles 0..32; `result_valid` in cycle 33 with `result`=42, `dest_out`=5, `status_out`=4'b0011.
- **MLA with wrap, N flag**
  - Stimulus: MLA Rm=0xFFFFFFFF, Rs=2, Rn=1.
  - Response: `result`=0xFFFFFFFF, `status_out[3]`=1.
- **Truncation, Z flag**
  - Stimulus: MUL 0x00010000*0x00010000.
  - Response: `result`=0, `status_out[2]`=1.
- **Flush mid-RUN**
  - Stimulus: `flush` in cycle 10.
  - Response: cycle 11 IDLE, `freeze`=0, no `result_valid`; `result` keeps its prior value.
- **Async reset mid-RUN**
  - Stimulus: `rst` pulse in cycle 15.
  - Response: all outputs 0 immediately; a new MUL 3*3 afterwards gives 9.
- **Early termination**
  - Stimulus: `MUL_EARLY_TERM_EN` defined, RADIX_BITS=1.
  - Response: Rs=3 gives `result_valid` in cycle 3; Rs=0 gives `result_valid` in cycle 2 with `result`=Rn for MLA.
